jk_cmd_sequencer: RTL and testbench

JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

---
 rtl/jk_seq_pkg.sv | 50 +++++
 rtl/jk_cmd_fifo.sv | 75 +++++++
 rtl/jk_cmd_sequencer.sv | 143 ++++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/jk_seq_pkg.sv
// -----------------------------------------------------------------------------
// jk_seq_pkg
// Shared types and helpers for the JK command sequencer:
//   jk_op_e    : 2-bit command opcode (HOLD, RST, SET, TGL)
//   jk_state_e : sequencer FSM state (IDLE, DRIVE)
//   op_to_jk() : maps an opcode to the {j,k} drive pair
//   jk_next_q(): behaviour of an ideal JK latch, used by the optional checker
// -----------------------------------------------------------------------------
package jk_seq_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,  // j=0 k=0
    RST  = 2'b01,  // j=0 k=1
    SET  = 2'b10,  // j=1 k=0
    TGL  = 2'b11   // j=1 k=1
  } jk_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } jk_state_e;

  // Returns {j, k} for a given opcode.
  function automatic logic [1:0] op_to_jk(input jk_op_e op);
    logic [1:0] jk;
    jk = 2'b00;
    case (op)
      HOLD:    jk = 2'b00;
      RST:     jk = 2'b01;
      SET:     jk = 2'b10;
      TGL:     jk = 2'b11;
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

  // Next state of an ideal JK latch given the current drive and state.
  function automatic logic jk_next_q(input logic j, input logic k, input logic q);
    logic nq;
    nq = q;
    case ({j, k})
      2'b01:   nq = 1'b0;
      2'b10:   nq = 1'b1;
      2'b11:   nq = ~q;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// -----------------------------------------------------------------------------
// jk_cmd_fifo
// In-order circular command buffer with an occupancy count of 0..DEPTH.
// Ports:
//   clk, rst           : clock, synchronous active-high reset (empties buffer)
//   push, wr_data      : write request and payload (ignored when full)
//   pop                : consume the head entry (ignored when empty)
//   rd_data            : current head entry, valid while empty==0
//   full, empty        : occupancy flags, derived from the registered count
// The head is read combinationally so the sequencer can pop and load a command
// on the same edge. A push into an empty buffer only becomes visible after the
// edge that writes it, so there is no write-to-read bypass.
// -----------------------------------------------------------------------------
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// jk_cmd_sequencer
// Queues JK drive commands and plays each one onto registered j/k outputs for
// cmd_len+1 cycles, back-to-back with no idle gap between queued commands.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   cmd_valid / cmd_ready  : command handshake (cmd_ready = FIFO not full)
//   cmd_op, cmd_len        : opcode (HOLD/RST/SET/TGL) and repeat count
//   j, k                   : registered drive to the downstream JK latch
//   busy                   : FSM driving or commands still queued
//   q_in                   : downstream latch output (checker input)
//   mismatch               : sticky checker failure flag
// Optional feature: define JK_SEQ_CHECK_EN to build a latch model that compares
// q_in against the expected latch state; otherwise mismatch is tied to 0.
// -----------------------------------------------------------------------------
module jk_cmd_sequencer
  import jk_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  output logic             busy,
  input  logic             q_in,
  output logic             mismatch
);

  localparam int DW = 2 + LEN_W;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [DW-1:0]    head;
  jk_op_e           head_op;
  logic [LEN_W-1:0] head_len;

  jk_state_e        state_q, state_d;
  logic [LEN_W-1:0] cnt_q,   cnt_d;
  logic             j_q,     j_d;
  logic             k_q,     k_d;

  assign cmd_ready = ~fifo_full;
  assign fifo_push = cmd_valid & ~fifo_full;

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data ({cmd_op, cmd_len}),
    .pop     (fifo_pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_op  = jk_op_e'(head[DW-1:LEN_W]);
  assign head_len = head[LEN_W-1:0];

  // A new command is loaded whenever one is queued and the current one (if any)
  // is on its final cycle; this gives gap-free back-to-back playback.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    j_d      = j_q;
    k_d      = k_q;
    fifo_pop = 1'b0;
    if (state_q == DRIVE && cnt_q != '0) begin
      cnt_d = cnt_q - LEN_W'(1);
    end else if (!fifo_empty) begin
      fifo_pop   = 1'b1;
      state_d    = DRIVE;
      cnt_d      = head_len;
      {j_d, k_d} = op_to_jk(head_op);
    end else begin
      state_d = IDLE;
      j_d     = 1'b0;
      k_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  assign j    = j_q;
  assign k    = k_q;
  assign busy = (state_q == DRIVE) | ~fifo_empty;

`ifdef JK_SEQ_CHECK_EN
  // q_exp follows the registered j/k one edge later, exactly as the external
  // latch does. Comparison is armed once the first command has been driven for
  // a full cycle, so q_in has had an edge to respond.
  logic q_exp_q,    q_exp_d;
  logic armed_q,    armed_d;
  logic mismatch_q, mismatch_d;

  always_comb begin
    q_exp_d    = jk_next_q(j_q, k_q, q_exp_q);
    armed_d    = armed_q | (state_q == DRIVE);
    mismatch_d = mismatch_q | (armed_q & (q_in != q_exp_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_exp_q    <= 1'b0;
      armed_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      q_exp_q    <= q_exp_d;
      armed_q    <= armed_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  logic unused_q_in;
  assign unused_q_in = q_in;
  assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jk_cmd_sequencer
// Directed bench for jk_cmd_sequencer (DEPTH=4, LEN_W=4). Inputs change 1 time
// unit after each rising edge; outputs are sampled at that same point.
// A behavioural JK latch drives q_in; force_low pins q_in to 0.
// -----------------------------------------------------------------------------
module tb_jk_cmd_sequencer;
  import jk_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_len;
  logic       j, k, busy;
  logic       q_in;
  logic       mismatch;
  logic       q_model;
  logic       force_low;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jk_cmd_sequencer #(.DEPTH(4), .LEN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .q_in      (q_in),
    .mismatch  (mismatch)
  );

  // Ideal downstream latch.
  always_ff @(posedge clk) begin
    if (rst)                    q_model <= 1'b0;
    else if ({j, k} == 2'b01)   q_model <= 1'b0;
    else if ({j, k} == 2'b10)   q_model <= 1'b1;
    else if ({j, k} == 2'b11)   q_model <= ~q_model;
  end
  assign q_in = force_low ? 1'b0 : q_model;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares {j,k,busy} against the expected triple.
  task automatic chk_jkb(input string tag, input logic [2:0] exp);
    chk(tag, {5'd0, j, k, busy}, {5'd0, exp});
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = 4'd0;
    force_low = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk_jkb("reset_jkb", 3'b000);
    chk("reset_ready", {7'd0, cmd_ready}, 8'd1);
    chk("reset_mismatch", {7'd0, mismatch}, 8'd0);

    // Single SET len=0: one cycle of j=1,k=0
    push(SET, 4'd0);
    chk_jkb("set_queued", 3'b001);
    step();
    chk_jkb("set_drive", 3'b101);
    step();
    chk_jkb("set_done", 3'b000);
    chk("set_ready", {7'd0, cmd_ready}, 8'd1);

    // TGL len=3 then RST len=1 back-to-back
    push(TGL, 4'd3);
    chk_jkb("b2b_queued", 3'b001);
    push(RST, 4'd1);
    chk_jkb("b2b_tgl0", 3'b111);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_jkb($sformatf("b2b_tgl%0d", i), 3'b111);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      chk_jkb($sformatf("b2b_rst%0d", i), 3'b011);
    end
    step();
    chk_jkb("b2b_idle", 3'b000);

    // Fill the FIFO during a long TGL drive
    push(TGL, 4'd15);
    chk_jkb("fill_queued", 3'b001);
    step();
    chk_jkb("fill_long_start", 3'b111);
    push(SET, 4'd0);
    push(RST, 4'd0);
    push(TGL, 4'd0);
    chk("fill_ready_3", {7'd0, cmd_ready}, 8'd1);
    push(SET, 4'd1);
    chk("fill_ready_full", {7'd0, cmd_ready}, 8'd0);
    // A 5th command is offered but must be held off
    cmd_valid = 1'b1;
    cmd_op    = TGL;
    cmd_len   = 4'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fill_holdoff%0d", i), {7'd0, cmd_ready}, 8'd0);
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_jkb($sformatf("fill_long%0d", i), 3'b111);
    end
    // Full with a pop this cycle: the offered push must still be refused
    chk("fullpop_ready_before", {7'd0, cmd_ready}, 8'd0);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("fullpop_ready_after", {7'd0, cmd_ready}, 8'd1);
    chk_jkb("order_set", 3'b101);
    step();
    chk_jkb("order_rst", 3'b011);
    step();
    chk_jkb("order_tgl", 3'b111);
    step();
    chk_jkb("order_set1a", 3'b101);
    step();
    chk_jkb("order_set1b", 3'b101);
    step();
    chk_jkb("order_idle", 3'b000);
    chk("order_mismatch", {7'd0, mismatch}, 8'd0);

    // Reset mid-drive with two commands queued; push on the reset edge dropped
    push(SET, 4'd7);
    push(RST, 4'd0);
    chk_jkb("abort_drive", 3'b101);
    push(TGL, 4'd0);
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = TGL;
    cmd_len   = 4'd0;
    step();
    rst       = 1'b0;
    cmd_valid = 1'b0;
    chk_jkb("abort_reset", 3'b000);
    chk("abort_ready", {7'd0, cmd_ready}, 8'd1);
    chk("abort_mismatch", {7'd0, mismatch}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_jkb($sformatf("abort_quiet%0d", i), 3'b000);
    end

`ifdef JK_SEQ_CHECK_EN
    // Correct latch through SET, TGL x3, RST
    push(SET, 4'd0);
    push(TGL, 4'd0);
    push(TGL, 4'd0);
    push(TGL, 4'd0);
    push(RST, 4'd0);
    for (int i = 0; i < 4; i++) step();
    chk("check_clean", {7'd0, mismatch}, 8'd0);
    // q_in stuck low during a SET
    force_low = 1'b1;
    push(SET, 4'd2);
    for (int i = 0; i < 4; i++) step();
    chk("check_flag", {7'd0, mismatch}, 8'd1);
    force_low = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("check_sticky", {7'd0, mismatch}, 8'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("check_cleared", {7'd0, mismatch}, 8'd0);
`else
    // Without the checker, mismatch stays 0 even with q_in misbehaving
    force_low = 1'b1;
    push(SET, 4'd2);
    for (int i = 0; i < 4; i++) step();
    chk("nocheck_tied", {7'd0, mismatch}, 8'd0);
    force_low = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
